press_decoder: RTL and testbench
================================

PRESS_DECODER -- requirements
Module: press_decoder

Interface
REQ-001 SHALL have parameter N, default 13, width of the free-running tick prescaler; tick period is 2^N clk cycles.
REQ-002 SHALL have parameter LONG_TICKS, default 50, ticks of continuous hold that classify a press as long (range 2..255).
REQ-003 SHALL have parameter GAP_TICKS, default 25, maximum ticks of release between two presses for a double click (range 2..255).
REQ-004 clk  input  1  rising-edge system clock.
REQ-005 reset  input  1  reset, asynchronous, active-high.
REQ-006 db  input  1  debounced button level, synchronous to clk, 1 = pressed.
REQ-007 press_tick  output  1  one-cycle pulse on every accepted db rising edge.
REQ-008 short_press  output  1  one-cycle pulse: single press shorter than LONG_TICKS, not followed by a second press within GAP_TICKS.
REQ-009 long_press  output  1  one-cycle pulse when a hold reaches LONG_TICKS; the button is still pressed at that point.
REQ-010 double_click  output  1  one-cycle pulse on release of a second short press that began within GAP_TICKS.
REQ-011 held  output  1  level, registered copy of db.

Function
REQ-012 SHALL register db into db_d each cycle; rise = db & ~db_d, fall = ~db & db_d.
REQ-013 SHALL run an N-bit prescaler; m_tick asserts for one cycle when the prescaler equals all-ones and the prescaler then wraps to 0.
REQ-014 SHALL keep an 8-bit tick counter cnt, cleared on every state entry, incremented on m_tick, saturating at 255.
REQ-015 FSM states: IDLE, PRESS1, GAP, PRESS2, LONG.
REQ-016 IDLE: rise -> PRESS1, press_tick.
REQ-017 PRESS1: fall -> GAP; else cnt reaching LONG_TICKS -> LONG, long_press.
REQ-018 GAP: rise -> PRESS2, press_tick; else cnt reaching GAP_TICKS -> IDLE, short_press.
REQ-019 PRESS2: fall -> IDLE, double_click; else cnt reaching LONG_TICKS -> LONG, short_press and long_press in the same cycle.
REQ-020 LONG: fall -> IDLE, no pulse; LONG_TICKS is never re-armed during the same hold.
REQ-021 When rise/fall and the cnt threshold occur in the same cycle, the edge SHALL take priority.
REQ-022 All pulse outputs SHALL be registered, asserting in the cycle after the clock edge that sampled the triggering condition, for exactly one cycle.
REQ-023 At most one of short_press, double_click, and the pair (short_press, long_press) SHALL fire per FSM transition; press_tick SHALL never coincide with short_press or double_click.
REQ-024 Hold and gap durations SHALL be accurate to +/-1 tick, because the prescaler phase is free-running.

Reset
REQ-025 Reset SHALL force state to IDLE and clear prescaler and cnt; all outputs SHALL be 0.
REQ-026 Reset SHALL set db_d to 1, so a button held through reset release produces no press_tick until it is released and pressed again.
REQ-027 Reset asserted mid-press or mid-gap SHALL discard the event; no pulse SHALL be emitted on reset entry or exit.

Structure
REQ-028 A shared package SHALL hold the state encoding (3-bit, IDLE = 0) and default values for N, LONG_TICKS and GAP_TICKS.
REQ-029 The prescaler SHALL be a sub-module tick_gen (parameter N, ports clk, reset, tick).
REQ-030 The FSM and output registers SHALL live in press_decoder; RTL target is 150-250 lines.

Verification (N=2, so one tick every 4 cycles; LONG_TICKS=4; GAP_TICKS=3)
REQ-031 db high 6 cycles, then low 20 cycles -> press_tick once; short_press once, 9-16 cycles after the fall; nothing else.
REQ-032 db high 30 cycles -> press_tick, then long_press while db=1 (13-20 cycles after rise); on release no short_press or double_click.
REQ-033 db high 5, low 4, high 5, low -> press_tick twice, double_click once one cycle after the second fall, short_press never.
REQ-034 db high 5, low 4, high 30 -> press_tick twice, then short_press and long_press in the same cycle; release gives no pulse.
REQ-035 Reset pulse while db=1 in PRESS1, db kept high 40 cycles then low then high -> no pulse until the second rise, which gives press_tick.
REQ-036 db toggling every cycle for 20 cycles -> press_tick per accepted rise, no long_press, and no two pulse outputs high in the same cycle except the REQ-019 pair.

Source files
------------

// File: rtl/press_decoder_pkg.sv
// Shared types and defaults for the push-button press decoder.
package press_decoder_pkg;

    localparam int N_DEF          = 13;
    localparam int LONG_TICKS_DEF = 50;
    localparam int GAP_TICKS_DEF  = 25;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_PRESS1 = 3'd1,
        ST_GAP    = 3'd2,
        ST_PRESS2 = 3'd3,
        ST_LONG   = 3'd4
    } state_e;

    // Tick counter increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/tick_gen.sv
// Free-running N-bit prescaler; tick is high while the count is all-ones.
module tick_gen
    import press_decoder_pkg::*;
#(
    parameter int N = N_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [N-1:0] pre_q;
    logic [N-1:0] pre_d;

    always_comb begin
        pre_d = pre_q + N'(1);
    end

    assign tick = &pre_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pre_q <= '0;
        end else begin
            pre_q <= pre_d;
        end
    end

endmodule

// File: rtl/press_decoder.sv
// Classifies a debounced button into press, short, long and double-click
// pulses using a tick-based hold/gap timer.
module press_decoder
    import press_decoder_pkg::*;
#(
    parameter int N          = N_DEF,
    parameter int LONG_TICKS = LONG_TICKS_DEF,
    parameter int GAP_TICKS  = GAP_TICKS_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic press_tick,
    output logic short_press,
    output logic long_press,
    output logic double_click,
    output logic held
);

    localparam logic [7:0] LONG_TH = LONG_TICKS[7:0];
    localparam logic [7:0] GAP_TH  = GAP_TICKS[7:0];

    state_e     state_q, state_d;
    logic [7:0] cnt_q, cnt_d;
    logic       db_q, db_d;
    logic       held_q, held_d;
    logic       pt_q, pt_d;
    logic       sp_q, sp_d;
    logic       lp_q, lp_d;
    logic       dc_q, dc_d;
    logic       m_tick;
    logic       rise;
    logic       fall;

    tick_gen #(.N(N)) u_tick (
        .clk   (clk),
        .reset (reset),
        .tick  (m_tick)
    );

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    // Edges are tested before the timer threshold so they win a tie.
    always_comb begin
        state_d = state_q;
        cnt_d   = m_tick ? sat_inc(cnt_q) : cnt_q;
        db_d    = db;
        held_d  = db;
        pt_d    = 1'b0;
        sp_d    = 1'b0;
        lp_d    = 1'b0;
        dc_d    = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d = ST_PRESS1;
                    pt_d    = 1'b1;
                end
            end
            ST_PRESS1: begin
                if (fall) begin
                    state_d = ST_GAP;
                end else if (cnt_q >= LONG_TH) begin
                    state_d = ST_LONG;
                    lp_d    = 1'b1;
                end
            end
            ST_GAP: begin
                if (rise) begin
                    state_d = ST_PRESS2;
                    pt_d    = 1'b1;
                end else if (cnt_q >= GAP_TH) begin
                    state_d = ST_IDLE;
                    sp_d    = 1'b1;
                end
            end
            ST_PRESS2: begin
                if (fall) begin
                    state_d = ST_IDLE;
                    dc_d    = 1'b1;
                end else if (cnt_q >= LONG_TH) begin
                    state_d = ST_LONG;
                    sp_d    = 1'b1;
                    lp_d    = 1'b1;
                end
            end
            ST_LONG: begin
                if (fall) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (state_d != state_q) begin
            cnt_d = 8'd0;
        end
    end

    // db_q resets high so a button held through reset is not seen as a press.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_IDLE;
            cnt_q   <= 8'd0;
            db_q    <= 1'b1;
            held_q  <= 1'b0;
            pt_q    <= 1'b0;
            sp_q    <= 1'b0;
            lp_q    <= 1'b0;
            dc_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            held_q  <= held_d;
            pt_q    <= pt_d;
            sp_q    <= sp_d;
            lp_q    <= lp_d;
            dc_q    <= dc_d;
        end
    end

    assign press_tick   = pt_q;
    assign short_press  = sp_q;
    assign long_press   = lp_q;
    assign double_click = dc_q;
    assign held         = held_q;

endmodule

// File: tb/tb_press_decoder.sv
// Scoreboard bench for press_decoder with N=2, LONG_TICKS=4, GAP_TICKS=3.
module tb_press_decoder;

    localparam logic [3:0] PT = 4'b1000;
    localparam logic [3:0] SP = 4'b0100;
    localparam logic [3:0] LP = 4'b0010;
    localparam logic [3:0] DC = 4'b0001;
    localparam logic [3:0] SL = 4'b0110;

    logic clk = 1'b0;
    logic reset;
    logic db;
    logic press_tick, short_press, long_press, double_click, held;

    typedef struct {
        logic [3:0] kind;
        int         cyc;
        logic       held;
    } ev_t;

    ev_t        obs_q[$];
    logic [3:0] exp_q[$];
    int         cyc    = 0;
    int         errors = 0;
    int         checks = 0;

    press_decoder #(.N(2), .LONG_TICKS(4), .GAP_TICKS(3)) dut (
        .clk          (clk),
        .reset        (reset),
        .db           (db),
        .press_tick   (press_tick),
        .short_press  (short_press),
        .long_press   (long_press),
        .double_click (double_click),
        .held         (held)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if ({press_tick, short_press, long_press, double_click} != 4'b0)
            obs_q.push_back('{kind: {press_tick, short_press, long_press, double_click},
                              cyc: cyc, held: held});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic hold(input logic v, input int n);
        db = v;
        step(n);
    endtask

    task automatic test_reset;
        reset = 1'b1;
        db    = 1'b0;
        step(3);
        checks++;
        if ({press_tick, short_press, long_press, double_click, held} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs: got %b want 00000",
                     {press_tick, short_press, long_press, double_click, held});
        end
        db = 1'b1;
        step(2);
        checks++;
        if (held !== 1'b0) begin
            errors++;
            $display("FAIL reset_held: got %b want 0", held);
        end
        reset = 1'b0;
        step(10);
        checks++;
        if (held !== 1'b1) begin
            errors++;
            $display("FAIL held_after_reset: got %b want 1", held);
        end
        hold(1'b0, 20);
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL held_through_reset: got %0d events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_short;
        int fall_c;
        logic [3:0] k;
        ev_t e;
        exp_q.push_back(PT);
        hold(1'b1, 6);
        fall_c = cyc;
        exp_q.push_back(SP);
        hold(1'b0, 20);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL short_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL short_kind: got %b want %b", e.kind, k);
                end else if (k == SP && (e.cyc - fall_c < 9 || e.cyc - fall_c > 16)) begin
                    errors++;
                    $display("FAIL short_delay: got %0d want 9..16", e.cyc - fall_c);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL short_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_long;
        int rise_c;
        logic [3:0] k;
        ev_t e;
        rise_c = cyc;
        exp_q.push_back(PT);
        hold(1'b1, 30);
        exp_q.push_back(LP);
        hold(1'b0, 20);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL long_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL long_kind: got %b want %b", e.kind, k);
                end else if (k == PT && e.cyc != rise_c + 1) begin
                    errors++;
                    $display("FAIL long_pt_time: got %0d want %0d", e.cyc, rise_c + 1);
                end else if (k == LP && (e.cyc - rise_c < 13 || e.cyc - rise_c > 20 || !e.held)) begin
                    errors++;
                    $display("FAIL long_delay: got %0d held=%b want 13..20 held=1",
                             e.cyc - rise_c, e.held);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL long_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_double;
        int fall_c;
        logic [3:0] k;
        ev_t e;
        exp_q.push_back(PT);
        hold(1'b1, 5);
        hold(1'b0, 4);
        exp_q.push_back(PT);
        hold(1'b1, 5);
        fall_c = cyc;
        exp_q.push_back(DC);
        hold(1'b0, 25);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL double_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL double_kind: got %b want %b", e.kind, k);
                end else if (k == DC && e.cyc != fall_c + 1) begin
                    errors++;
                    $display("FAIL double_time: got %0d want %0d", e.cyc, fall_c + 1);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL double_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_short_long;
        logic [3:0] k;
        ev_t e;
        exp_q.push_back(PT);
        hold(1'b1, 5);
        hold(1'b0, 4);
        exp_q.push_back(PT);
        hold(1'b1, 30);
        exp_q.push_back(SL);
        hold(1'b0, 25);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL shlong_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL shlong_kind: got %b want %b", e.kind, k);
                end else if (k == SL && !e.held) begin
                    errors++;
                    $display("FAIL shlong_held: got %b want 1", e.held);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL shlong_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_reset_mid;
        int rise_c;
        logic [3:0] k;
        ev_t e;
        exp_q.push_back(PT);
        hold(1'b1, 3);
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        hold(1'b1, 40);
        hold(1'b0, 10);
        rise_c = cyc;
        exp_q.push_back(PT);
        hold(1'b1, 5);
        exp_q.push_back(SP);
        hold(1'b0, 25);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL rstmid_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL rstmid_kind: got %b want %b", e.kind, k);
                end else if (k == PT && exp_q.size() == 1 && e.cyc != rise_c + 1) begin
                    errors++;
                    $display("FAIL rstmid_pt_time: got %0d want %0d", e.cyc, rise_c + 1);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL rstmid_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    task automatic test_toggle;
        logic [3:0] k;
        ev_t e;
        for (int i = 0; i < 20; i++) begin
            db = (i % 2 == 0);
            if (i % 2 == 0) exp_q.push_back(PT);
            else if ((i / 2) % 2 == 1) exp_q.push_back(DC);
            step(1);
        end
        hold(1'b0, 25);
        while (exp_q.size() > 0) begin
            k = exp_q.pop_front();
            checks++;
            if (obs_q.size() == 0) begin
                errors++;
                $display("FAIL toggle_missing: got none want %b", k);
            end else begin
                e = obs_q.pop_front();
                if (e.kind !== k) begin
                    errors++;
                    $display("FAIL toggle_kind: got %b want %b at cyc %0d", e.kind, k, e.cyc);
                end
            end
        end
        checks++;
        if (obs_q.size() != 0) begin
            errors++;
            $display("FAIL toggle_extra: got %0d extra events want 0", obs_q.size());
        end
        obs_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        db    = 1'b0;
        @(posedge clk);
        #1;
        test_reset;
        test_short;
        test_long;
        test_double;
        test_short_long;
        test_reset_mid;
        test_toggle;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
